// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle SLL/SRL/SRA unit for the execute stage. Shifts the operand at
//   most STEP bits per clock and holds the pipeline via stall until the result
//   is ready.
//
//   Parameters
//     STEP       maximum bits shifted per cycle (1, 2, 4, 8 or 16)
//   Ports
//     clk        system clock, rising edge
//     rst_n      synchronous active-low reset
//     start      shift request, sampled only while idle
//     op         00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through)
//     var_sel    1: amount from rs_data[4:0], 0: amount from shamt_ext[4:0]
//     shamt_ext  zero-extended instruction shamt (only [4:0] used)
//     rs_data    register rs value (only [4:0] used)
//     data_in    operand to shift
//     result     registered result, updated on entry to DONE and held
//     done       one-cycle pulse, result valid
//     busy       high whenever not idle
//     stall      pipeline hold request
module shift_sequencer #(
    parameter int unsigned STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        var_sel,
    input  logic [31:0] shamt_ext,
    input  logic [31:0] rs_data,
    input  logic [31:0] data_in,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  rem_q, rem_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;

    logic [4:0]  amt_sel;
    logic [4:0]  step_s;
    logic [32:0] sra_ext;
    logic        unused_hi;

    assign unused_hi = ^{shamt_ext[31:5], rs_data[31:5]};

    // Selected shift amount and the bits to shift this cycle: min(remaining, STEP)
    always_comb begin
        amt_sel = var_sel ? rs_data[4:0] : shamt_ext[4:0];
        step_s  = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (amt_sel != 5'd0 && op != 2'b11) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // Last slice: remaining - s reaches zero this cycle
                if (rem_q == step_s) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        op_d     = op_q;
        work_d   = work_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        result_d = result_q;
        // Sign bit prepended so the arithmetic shift fills with the latched sign
        sra_ext  = $signed({sign_q, work_q}) >>> step_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    work_d = data_in;
                    rem_d  = amt_sel;
                    sign_d = data_in[31];
                end
            end
            SHIFT: begin
                rem_d = rem_q - step_s;
                case (op_q)
                    2'b00:   work_d = work_q << step_s;
                    2'b01:   work_d = work_q >> step_s;
                    2'b10:   work_d = sra_ext[31:0];
                    default: work_d = work_q;
                endcase
            end
            default: ;
        endcase

        // Capture on the edge that enters DONE so result is valid alongside done
        if (state_d == DONE) begin
            result_d = work_d;
        end
    end

    // Outputs
    always_comb begin
        result = result_q;
        done   = (state_q == DONE);
        busy   = (state_q != IDLE);
        stall  = rst_n && ((state_q == IDLE && start) || state_q == SHIFT);
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        var_sel;
    logic [31:0] shamt_ext;
    logic [31:0] rs_data;
    logic [31:0] data_in;

    logic [31:0] res_w   [3];
    logic        done_w  [3];
    logic        busy_w  [3];
    logic        stall_w [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    shift_sequencer #(.STEP(1)) u_step1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .var_sel(var_sel),
        .shamt_ext(shamt_ext), .rs_data(rs_data), .data_in(data_in),
        .result(res_w[0]), .done(done_w[0]), .busy(busy_w[0]), .stall(stall_w[0])
    );

    shift_sequencer #(.STEP(4)) u_step4 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .var_sel(var_sel),
        .shamt_ext(shamt_ext), .rs_data(rs_data), .data_in(data_in),
        .result(res_w[1]), .done(done_w[1]), .busy(busy_w[1]), .stall(stall_w[1])
    );

    shift_sequencer #(.STEP(16)) u_step16 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .var_sel(var_sel),
        .shamt_ext(shamt_ext), .rs_data(rs_data), .data_in(data_in),
        .result(res_w[2]), .done(done_w[2]), .busy(busy_w[2]), .stall(stall_w[2])
    );

    function automatic int step_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    // Result of the whole operation in one go
    function automatic logic [31:0] exp_shift(input logic [1:0] o, input logic [4:0] a,
                                              input logic [31:0] d);
        logic signed [31:0] sd;
        sd = $signed(d);
        case (o)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return $unsigned(sd >>> a);
            default: return d;
        endcase
    endfunction

    // Number of SHIFT cycles: ceil(amt/STEP), none for zero amount or reserved op
    function automatic int exp_k(input logic [1:0] o, input logic [4:0] a, input int i);
        if (a == 5'd0 || o == 2'b11) return 0;
        return (int'(a) + step_of(i) - 1) / step_of(i);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: m_left counts cycles until idle (1 = the done cycle)
    int          m_left [3];
    logic [31:0] m_res  [3];
    logic [31:0] m_pend [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_left[i] = 0;
            m_res[i]  = '0;
            m_pend[i] = '0;
        end
    end

    always @(posedge clk) begin
        logic [4:0] a;
        a = var_sel ? rs_data[4:0] : shamt_ext[4:0];
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_left[i] = 0;
                m_res[i]  = '0;
            end else begin
                if (m_left[i] > 0) begin
                    m_left[i]--;
                end else if (start) begin
                    m_left[i] = exp_k(op, a, i) + 1;
                    m_pend[i] = exp_shift(op, a, data_in);
                end
                if (m_left[i] == 1) m_res[i] = m_pend[i];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("dut%0d done", i), 32'(done_w[i]), 32'(m_left[i] == 1));
                check($sformatf("dut%0d busy", i), 32'(busy_w[i]), 32'(m_left[i] > 0));
                check($sformatf("dut%0d stall", i), 32'(stall_w[i]),
                      32'(rst_n && ((m_left[i] == 0 && start) || m_left[i] > 1)));
                check($sformatf("dut%0d result", i), res_w[i], m_res[i]);
            end
        end
    end

    // Directed operation with hand-computed result and done cycle per DUT
    // (STEP 1, 4, 16). Called at posedge+1 with all DUTs idle.
    task automatic directed(input string nm, input logic [1:0] o, input logic vs,
                            input logic [31:0] sh, input logic [31:0] rs,
                            input logic [31:0] din, input logic [31:0] exp_r,
                            input int c0, input int c1, input int c2, input bit poke);
        int          cyc    [3];
        int          pulses [3];
        logic [31:0] got    [3];
        int          exp_c  [3];
        exp_c = '{c0, c1, c2};
        for (int i = 0; i < 3; i++) begin
            cyc[i]    = -1;
            pulses[i] = 0;
            got[i]    = '0;
        end
        op = o; var_sel = vs; shamt_ext = sh; rs_data = rs; data_in = din; start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    pulses[i]++;
                    if (cyc[i] < 0) begin
                        cyc[i] = n;
                        got[i] = res_w[i];
                    end
                end
            end
            @(posedge clk);
            #1;
            if (n == 0) begin
                start = poke;
                if (poke) data_in = 32'hDEADBEEF;
            end else begin
                start   = 1'b0;
                data_in = $urandom();
                rs_data = $urandom();
                op      = 2'($urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s dut%0d done cycle", nm, i), 32'(cyc[i]), 32'(exp_c[i]));
            check($sformatf("%s dut%0d result", nm, i), got[i], exp_r);
            check($sformatf("%s dut%0d pulses", nm, i), 32'(pulses[i]), 32'd1);
        end
    endtask

    initial begin
        int pulses [3];
        rst_n = 1'b0; start = 1'b0; op = 2'b00; var_sel = 1'b0;
        shamt_ext = '0; rs_data = '0; data_in = '0;

        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset dut%0d busy", i), 32'(busy_w[i]), 32'd0);
            check($sformatf("reset dut%0d done", i), 32'(done_w[i]), 32'd0);
            check($sformatf("reset dut%0d result", i), res_w[i], 32'h0);
            check($sformatf("reset dut%0d stall", i), 32'(stall_w[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("sll5",   2'b00, 1'b0, 32'h5, 32'h0, 32'h1, 32'h20, 6, 3, 2, 1'b0);
        directed("sra31",  2'b10, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                 32, 9, 3, 1'b0);
        directed("srl31",  2'b01, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1,
                 32, 9, 3, 1'b0);
        directed("srl0",   2'b01, 1'b0, 32'h0, 32'h1F, 32'hF0000000, 32'hF0000000,
                 1, 1, 1, 1'b0);
        directed("resv7",  2'b11, 1'b0, 32'h7, 32'h0, 32'h12345678, 32'h12345678,
                 1, 1, 1, 1'b0);
        directed("mask4",  2'b00, 1'b0, 32'h24, 32'h0, 32'h1, 32'h10, 5, 2, 2, 1'b1);
        directed("sll17",  2'b00, 1'b0, 32'h11, 32'h0, 32'h1, 32'h00020000,
                 18, 6, 3, 1'b0);

        // Reset in the middle of an SRA by 20
        op = 2'b10; var_sel = 1'b0; shamt_ext = 32'd20; data_in = 32'h80001234; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midreset dut%0d busy", i), 32'(busy_w[i]), 32'd0);
            check($sformatf("midreset dut%0d done", i), 32'(done_w[i]), 32'd0);
            check($sformatf("midreset dut%0d result", i), res_w[i], 32'h0);
            pulses[i] = 0;
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done_w[i]) pulses[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midreset dut%0d pulses", i), 32'(pulses[i]), 32'd0);
        end
        @(posedge clk); #1;
        directed("sll1", 2'b00, 1'b0, 32'h1, 32'h0, 32'h3, 32'h6, 2, 2, 2, 1'b0);

        // Randomized traffic, checked every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            start     = 1'($urandom_range(0, 1));
            op        = 2'($urandom_range(0, 3));
            var_sel   = 1'($urandom_range(0, 1));
            shamt_ext = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 31));
            rs_data   = $urandom();
            data_in   = $urandom();
            rst_n     = ($urandom_range(0, 99) != 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
